// File: rtl/decode_dual_issue_scheduler_pkg.sv
// Shared types and helpers for the decode dual-issue scheduler.
//   sched_state_t   : scheduler FSM state (issue a pair, or drain the held second slot)
//   Reason*         : bit positions in the hazard reason vector
//   pair_conflict() : collapses a reason vector into a single split decision
package decode_dual_issue_scheduler_pkg;

  typedef enum logic {
    Pair,
    Second
  } sched_state_t;

  localparam int unsigned ReasonRaw    = 0;
  localparam int unsigned ReasonMem    = 1;
  localparam int unsigned ReasonSerial = 2;
  localparam int unsigned NumReasons   = 3;

  function automatic logic pair_conflict(input logic [NumReasons-1:0] reason);
    return |reason;
  endfunction

endpackage

// File: rtl/decode_dual_issue_scheduler_pair_hazard_check.sv
// Purely combinational intra-pair hazard check for a decoded instruction pair.
// Slot 0 is older; only slot 1 can depend on slot 0.
// Ports:
//   in_valid_i             : per-slot valid; hazards reported only when both are valid
//   uses_rd_i/rs1_i/rs2_i  : register usage flags per slot
//   rd_i/rs1_i/rs2_i       : register indices per slot
//   is_mem_i, serial_i     : memory access / serializing flags per slot
//   conflict_o             : pair must be split across two cycles
//   reason_o               : {serial, mem, raw} debug reason vector
module decode_dual_issue_scheduler_pair_hazard_check
  import decode_dual_issue_scheduler_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [1:0]            in_valid_i,
  input  logic [1:0]            uses_rd_i,
  input  logic [1:0]            uses_rs1_i,
  input  logic [1:0]            uses_rs2_i,
  input  logic [1:0][REG_W-1:0] rd_i,
  input  logic [1:0][REG_W-1:0] rs1_i,
  input  logic [1:0][REG_W-1:0] rs2_i,
  input  logic [1:0]            is_mem_i,
  input  logic [1:0]            serial_i,
  output logic                  conflict_o,
  output logic [NumReasons-1:0] reason_o
);

  logic both_valid;
  logic raw;

  assign both_valid = &in_valid_i;

  // x0 is hardwired zero, so writing it never creates a dependence.
  assign raw = uses_rd_i[0] & (rd_i[0] != '0) &
               ((uses_rs1_i[1] & (rs1_i[1] == rd_i[0])) |
                (uses_rs2_i[1] & (rs2_i[1] == rd_i[0])));

  always_comb begin
    reason_o               = '0;
    reason_o[ReasonRaw]    = both_valid & raw;
    reason_o[ReasonMem]    = both_valid & is_mem_i[0] & is_mem_i[1];
    reason_o[ReasonSerial] = both_valid & (serial_i[0] | serial_i[1]);
  end

  assign conflict_o = pair_conflict(reason_o);

  // Slot-1 destination and slot-0 sources play no part in the one-way check.
  logic unused_fields;
  assign unused_fields = ^{uses_rd_i[1], rd_i[1], uses_rs1_i[0], rs1_i[0],
                           uses_rs2_i[0], rs2_i[0]};

endmodule

// File: rtl/decode_dual_issue_scheduler.sv
// Dual-issue scheduler between decode and rename/issue. Issues a decoded pair together
// when independent; otherwise issues slot 0, holds slot 1 and stalls decode for a cycle.
// Ports:
//   clk, reset, flush       : clock, synchronous active-high reset, synchronous flush
//   in_*                    : per-slot decoded hazard fields and payload (slot 0 older)
//   stall_up                : decode ext_stall; decode holds its pair while high
//   out_ready               : downstream accepts the current outputs
//   out_valid, out_payload  : registered issue-side slots
//   split_count             : saturating count of split events (cleared by reset only)
module decode_dual_issue_scheduler
  import decode_dual_issue_scheduler_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [1:0]                in_valid,
  input  logic [1:0]                in_uses_rd,
  input  logic [1:0]                in_uses_rs1,
  input  logic [1:0]                in_uses_rs2,
  input  logic [1:0][REG_W-1:0]     in_rd,
  input  logic [1:0][REG_W-1:0]     in_rs1,
  input  logic [1:0][REG_W-1:0]     in_rs2,
  input  logic [1:0]                in_is_mem,
  input  logic [1:0]                in_serial,
  input  logic [1:0][PAYLOAD_W-1:0] in_payload,
  output logic                      stall_up,
  input  logic                      out_ready,
  output logic [1:0]                out_valid,
  output logic [1:0][PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]          split_count
);

  sched_state_t              state_q, state_d;
  logic [1:0]                valid_q, valid_d;
  logic [1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [PAYLOAD_W-1:0]      hold_q, hold_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                  adv;
  logic                  conflict;
  logic [NumReasons-1:0] unused_hazard_reason;

  decode_dual_issue_scheduler_pair_hazard_check #(
    .REG_W(REG_W)
  ) u_hazard (
    .in_valid_i (in_valid),
    .uses_rd_i  (in_uses_rd),
    .uses_rs1_i (in_uses_rs1),
    .uses_rs2_i (in_uses_rs2),
    .rd_i       (in_rd),
    .rs1_i      (in_rs1),
    .rs2_i      (in_rs2),
    .is_mem_i   (in_is_mem),
    .serial_i   (in_serial),
    .conflict_o (conflict),
    .reason_o   (unused_hazard_reason)
  );

  // Empty output registers can always be overwritten.
  assign adv      = out_ready | ~(valid_q[0] | valid_q[1]);
  assign stall_up = (state_q == Second) | ~adv;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    hold_d    = hold_q;
    count_d   = count_q;
    if (flush) begin
      state_d   = Pair;
      valid_d   = '0;
      payload_d = '0;
      hold_d    = '0;
    end else if (adv) begin
      unique case (state_q)
        Pair: begin
          unique case (in_valid)
            2'b00: valid_d = 2'b00;
            2'b01: begin
              payload_d[0] = in_payload[0];
              valid_d      = 2'b01;
            end
            2'b10: begin
              // Compact the lone younger instruction into slot 0.
              payload_d[0] = in_payload[1];
              valid_d      = 2'b01;
            end
            2'b11: begin
              if (conflict) begin
                payload_d[0] = in_payload[0];
                valid_d      = 2'b01;
                hold_d       = in_payload[1];
                state_d      = Second;
                if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
              end else begin
                payload_d = in_payload;
                valid_d   = 2'b11;
              end
            end
            default: ;
          endcase
        end
        Second: begin
          payload_d[0] = hold_q;
          valid_d      = 2'b01;
          state_d      = Pair;
        end
        default: state_d = Pair;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= Pair;
      valid_q   <= '0;
      payload_q <= '0;
      hold_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign split_count = count_q;

endmodule
